// File: rtl/page_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | page_loader: streams upstream bytes into a 256x8 page RAM, one page at a  |
// | time, and holds the finished page until the consumer acknowledges it.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module page_loader #(
  parameter int PAGE_BYTES = 256
) (
  input  logic       hw_clk,
  input  logic       hw_rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       page_done,
  output logic [8:0] page_len,
  output logic       page_full,
  input  logic       page_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] c_last_ptr = 8'(PAGE_BYTES - 1);

  state_t     r_state;
  logic [7:0] r_wr_ptr;
  logic       w_accept;
  logic       w_at_limit;

  // Ready comes from registered state only, so upstream sees no comb loop.
  assign in_ready   = (r_state == IDLE) || (r_state == LOAD);
  assign w_accept   = in_valid && in_ready;
  assign w_at_limit = (r_wr_ptr == c_last_ptr);

  always_ff @(posedge hw_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      r_state   <= IDLE;
      r_wr_ptr  <= 8'd0;
      ram_we    <= 1'b0;
      ram_addr  <= 8'd0;
      ram_wdata <= 8'd0;
      page_done <= 1'b0;
      page_len  <= 9'd0;
      page_full <= 1'b0;
    end else begin
      ram_we <= w_accept;
      if (w_accept) begin
        ram_addr  <= r_wr_ptr;
        ram_wdata <= in_data;
        r_wr_ptr  <= r_wr_ptr + 8'd1;
      end

      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            if (in_last || w_at_limit) begin
              r_state   <= FLUSH;
              // 9-bit count so a full 256-byte page does not wrap to zero.
              page_len  <= {1'b0, r_wr_ptr} + 9'd1;
              page_full <= !in_last;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        FLUSH: begin
          r_state   <= DONE;
          page_done <= 1'b1;
        end
        DONE: begin
          if (page_ack) begin
            r_state   <= IDLE;
            page_done <= 1'b0;
            r_wr_ptr  <= 8'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_page_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_page_loader: scoreboard bench for page_loader RAM writes and page      |
// | completion status.                                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_page_loader;

  logic       hw_clk;
  logic       hw_rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       page_done;
  logic [8:0] page_len;
  logic       page_full;
  logic       page_ack;

  page_loader #(.PAGE_BYTES(256)) dut (
    .hw_clk    (hw_clk),
    .hw_rst_n  (hw_rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .page_done (page_done),
    .page_len  (page_len),
    .page_full (page_full),
    .page_ack  (page_ack)
  );

  typedef struct packed {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  mptr     = 0;

  initial hw_clk = 1'b0;
  always #5 hw_clk = ~hw_clk;
  always @(posedge hw_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every RAM write must match the oldest expected write, in the expected cycle.
  always @(negedge hw_clk) begin
    if (ram_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, ram_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", ram_addr, e.addr);
        check("wr_data", ram_wdata, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge hw_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    step();
    exp_q.push_back('{cyc: cyc, addr: 8'(mptr), data: d});
    mptr++;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the final byte's accept edge.
  task automatic wait_done(input int len, input logic full);
    check("done_early", page_done, 1'b0);
    check("ready_in_flush", in_ready, 1'b0);
    step();
    check("page_done", page_done, 1'b1);
    check("page_len", page_len, len);
    check("page_full", page_full, full);
    check("ready_in_done", in_ready, 1'b0);
  endtask

  task automatic ack();
    page_ack = 1'b1;
    step();
    page_ack = 1'b0;
    check("done_after_ack", page_done, 1'b0);
    check("ready_after_ack", in_ready, 1'b1);
    mptr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0;
    in_data  = 8'd0;
    in_last  = 1'b0;
    page_ack = 1'b0;
    hw_rst_n = 1'b0;
    repeat (3) step();
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 8'd0);
    check("rst_ram_wdata", ram_wdata, 8'd0);
    check("rst_page_done", page_done, 1'b0);
    check("rst_page_len", page_len, 9'd0);
    check("rst_page_full", page_full, 1'b0);
    hw_rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1'b1);

    // Three back-to-back bytes.
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    wait_done(3, 1'b0);
    ack();

    // Single-byte page straight from IDLE.
    send(8'hA5, 1'b1);
    wait_done(1, 1'b0);
    ack();

    // Full page ended by the count limit; next byte stalls until ack.
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
    check("ready_after_256", in_ready, 1'b0);
    wait_done(256, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_last  = 1'b1;
    repeat (3) step();
    check("held_page_done", page_done, 1'b1);
    ack();
    send(8'h5A, 1'b1);
    wait_done(1, 1'b0);
    ack();

    // in_last on the limit byte reports a non-full page.
    for (int i = 0; i < 256; i++) send(8'(255 - i), i == 255);
    wait_done(256, 1'b0);
    ack();

    // Valid toggled every other cycle.
    for (int i = 0; i < 4; i++) begin
      send(8'(8'hC0 + i), i == 3);
      if (i < 3) step();
    end
    wait_done(4, 1'b0);
    ack();

    // Reset in the middle of a page.
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b0);
    step();
    hw_rst_n = 1'b0;
    #1;
    check("midrst_ram_addr", ram_addr, 8'd0);
    check("midrst_ram_wdata", ram_wdata, 8'd0);
    check("midrst_page_len", page_len, 9'd0);
    check("midrst_ram_we", ram_we, 1'b0);
    repeat (2) step();
    hw_rst_n = 1'b1;
    mptr = 0;
    repeat (3) step();
    check("midrst_no_done", page_done, 1'b0);
    send(8'h77, 1'b0);
    send(8'h78, 1'b1);
    wait_done(2, 1'b0);
    ack();

    // page_ack held during LOAD must not disturb the page.
    send(8'h90, 1'b0);
    page_ack = 1'b1;
    send(8'h91, 1'b0);
    step();
    send(8'h92, 1'b0);
    page_ack = 1'b0;
    send(8'h93, 1'b1);
    wait_done(4, 1'b0);
    step();
    check("done_holds", page_done, 1'b1);
    ack();

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/page_loader.md
PAGE_LOADER -- requirements
Module: page_loader

Interface
REQ-001 Parameter: PAGE_BYTES, default 256, maximum bytes per page (2..256).
REQ-002 Port: hw_clk  input  1  single clock for all state; rising edge.
REQ-003 Port: hw_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  upstream byte valid.
REQ-005 Port: in_data  input  8  upstream byte.
REQ-006 Port: in_last  input  1  marks final byte of page; sampled only on accept.
REQ-007 Port: in_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port: ram_we  output  1  write strobe to 256x8 page RAM, one cycle per byte.
REQ-009 Port: ram_addr  output  8  write address.
REQ-010 Port: ram_wdata  output  8  write data.
REQ-011 Port: page_done  output  1  level; page complete and fully committed to RAM.
REQ-012 Port: page_len  output  9  byte count of completed page, 1..PAGE_BYTES.
REQ-013 Port: page_full  output  1  page ended by count limit, not by in_last.
REQ-014 Port: page_ack  input  1  consumer releases page; loader rearms.

Function
REQ-015 The block SHALL be a state machine with states IDLE, LOAD, FLUSH, DONE.
REQ-016 Accept SHALL occur when in_valid && in_ready at a rising edge; in_ready SHALL be 1 in IDLE and LOAD, 0 in FLUSH and DONE, decoded from registered state only (no combinational path from in_valid).
REQ-017 On accept, the next cycle SHALL present ram_we=1, ram_addr=wr_ptr, ram_wdata=in_data; wr_ptr SHALL increment by 1; ram_we SHALL be 0 in all cycles not following an accept.
REQ-018 Write latency: exactly 1 cycle from accept edge to ram_we high; ram outputs registered.
REQ-019 IDLE -> LOAD on accept with in_last=0; IDLE -> FLUSH on accept with in_last=1 (1-byte page).
REQ-020 LOAD -> FLUSH on accept with in_last=1, or on accept when wr_ptr==PAGE_BYTES-1 (limit); otherwise stay in LOAD, including cycles with in_valid=0.
REQ-021 FLUSH SHALL last exactly 1 cycle (the final byte's ram_we cycle) then go to DONE.
REQ-022 page_done SHALL be 1 only in DONE, thus first high the cycle after the last ram_we.
REQ-023 page_len SHALL be loaded on entry to FLUSH with the 9-bit accepted count (wr_ptr+1) and held until next page completes; arithmetic in 9 bits, so a 256-byte page reports 256 without wrap.
REQ-024 page_full SHALL be set on entry to FLUSH when the limit ended the page and in_last=0; cleared when in_last ended it; in_last coincident with the limit byte SHALL give page_full=0.
REQ-025 In DONE, page_ack=1 SHALL move to IDLE next cycle with wr_ptr=0; page_done, page_len, page_full hold until then; page_ack SHALL be ignored in other states.
REQ-026 wr_ptr SHALL never wrap mid-page; bytes offered while in_ready=0 SHALL not be accepted or written.

Reset
REQ-027 hw_rst_n=0 SHALL immediately force IDLE, wr_ptr=0, ram_we=0, ram_addr=0, ram_wdata=0, page_done=0, page_len=0, page_full=0; in_ready=1 after release.
REQ-028 Reset mid-page SHALL discard the partial page: no further ram_we, no page_done; the next accepted byte after release SHALL be written to address 0.

Verification
REQ-029 Bytes 0x11,0x22,0x33 (last on 0x33), back-to-back -> ram_we at addr 0,1,2 with those data on 3 consecutive cycles; page_done next cycle; page_len=3, page_full=0.
REQ-030 Single byte 0xA5 with in_last from IDLE -> one write addr 0 data 0xA5; page_done 2 cycles after accept; page_len=1.
REQ-031 256 bytes 0x00..0xFF, in_last=0 -> writes addr 0..255; in_ready=0 after 256th accept; page_len=256, page_full=1; 257th byte held until page_ack, then written to addr 0.
REQ-032 in_valid toggled every other cycle for 4 bytes with in_last on 4th -> exactly 4 ram_we pulses, addr 0..3, no write in gap cycles; page_len=4.
REQ-033 hw_rst_n pulsed low after 5 of 10 bytes accepted -> outputs zero immediately; no page_done; next byte after release written to addr 0.
REQ-034 page_ack held high during LOAD, then low, then pulsed in DONE -> no effect in LOAD; IDLE one cycle after DONE pulse.
